// File: rtl/cache_pkg.sv
// cache_pkg: shared FSM state and owner types plus default bus widths for the cache RAM arbiter
package cache_pkg;
  localparam int CACHE_ADDR_W = 32;
  localparam int CACHE_DATA_W = 32;
  typedef enum logic [1:0] {IDLE, XFER_D, XFER_I, DONE} state_t;
  typedef enum logic {OWN_D, OWN_I} owner_t;
endpackage

// File: rtl/ram_req_prio.sv
// ram_req_prio: IDLE-state D/I grant choice with a saturating D-over-I starvation counter
// Ports: clk, rst (async, active-high); idle qualifies grants; d_req/i_req in; grant_d/grant_i out (one-hot or none).
module ram_req_prio #(
  parameter int STARVE_MAX = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic idle,
  input  logic d_req,
  input  logic i_req,
  output logic grant_d,
  output logic grant_i
);
  localparam int CW = $clog2(STARVE_MAX + 2);
  logic [CW-1:0] starve_cnt;
  logic below;
  always_comb begin
    below = starve_cnt < CW'(STARVE_MAX);
    grant_d = idle && d_req && (!i_req || below);
    grant_i = idle && i_req && !grant_d;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) starve_cnt <= '0;
    else if (grant_i) starve_cnt <= '0;
    else if (grant_d && i_req && below) starve_cnt <= starve_cnt + 1'b1;
endmodule

// File: rtl/cache_ram_arbiter.sv
// cache_ram_arbiter: shares one RAM port between D-cache line refill/write-back and I-cache line refill
// Ports: clk, rst (async, active-high); d_req/d_we/d_addr/d_wdata and i_req/i_addr from the caches;
// d_beat/i_beat, d_rvalid/i_rvalid, d_done/i_done, rdata back to the caches; ram_en/ram_we/ram_addr/
// ram_wdata to the RAM with ram_rdata/ram_resp from it; busy while any line is in flight.
module cache_ram_arbiter import cache_pkg::*; #(
  parameter int ADDR_W     = CACHE_ADDR_W,
  parameter int DATA_W     = CACHE_DATA_W,
  parameter int LINE_WORDS = 4,
  parameter int STARVE_MAX = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          d_req,
  input  logic                          d_we,
  input  logic [ADDR_W-1:0]             d_addr,
  input  logic [DATA_W-1:0]             d_wdata,
  output logic [$clog2(LINE_WORDS)-1:0] d_beat,
  output logic                          d_rvalid,
  output logic                          d_done,
  input  logic                          i_req,
  input  logic [ADDR_W-1:0]             i_addr,
  output logic [$clog2(LINE_WORDS)-1:0] i_beat,
  output logic                          i_rvalid,
  output logic                          i_done,
  output logic [DATA_W-1:0]             rdata,
  output logic                          ram_en,
  output logic                          ram_we,
  output logic [ADDR_W-1:0]             ram_addr,
  output logic [DATA_W-1:0]             ram_wdata,
  input  logic [DATA_W-1:0]             ram_rdata,
  input  logic                          ram_resp,
  output logic                          busy
);
  localparam int BW = $clog2(LINE_WORDS);
  localparam int WB = $clog2(DATA_W / 8);
  localparam logic [ADDR_W-1:0] LINE_MASK = ~ADDR_W'(LINE_WORDS * DATA_W / 8 - 1);
  state_t state, state_n;
  owner_t owner;
  logic [BW-1:0] beat;
  logic [ADDR_W-1:0] base;
  logic we, grant_d, grant_i, xfer, last;
  ram_req_prio #(.STARVE_MAX(STARVE_MAX)) u_prio (
    .clk    (clk),
    .rst    (rst),
    .idle   (state == IDLE),
    .d_req  (d_req),
    .i_req  (i_req),
    .grant_d(grant_d),
    .grant_i(grant_i)
  );
  always_comb begin
    xfer = state == XFER_D || state == XFER_I;
    last = beat == BW'(LINE_WORDS - 1);
    state_n = state == IDLE ? (grant_d ? XFER_D : grant_i ? XFER_I : IDLE)
            : xfer ? (ram_resp && last ? DONE : state)
            : IDLE;
    busy = state != IDLE;
    ram_en = xfer;
    ram_we = xfer && we;
    ram_addr = xfer ? base + (ADDR_W'(beat) << WB) : '0;
    ram_wdata = xfer ? d_wdata : '0;
    d_beat = busy && owner == OWN_D ? beat : '0;
    i_beat = busy && owner == OWN_I ? beat : '0;
    d_rvalid = state == XFER_D && ram_resp && !we;
    i_rvalid = state == XFER_I && ram_resp;
    d_done = state == DONE && owner == OWN_D;
    i_done = state == DONE && owner == OWN_I;
    rdata = ram_rdata;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      owner <= OWN_D;
      beat <= '0;
      base <= '0;
      we <= 1'b0;
    end else begin
      state <= state_n;
      if (grant_d || grant_i) begin
        owner <= grant_d ? OWN_D : OWN_I;
        base <= (grant_d ? d_addr : i_addr) & LINE_MASK;
        we <= grant_d && d_we;
        beat <= '0;
      end else if (xfer && ram_resp) beat <= beat + 1'b1;
    end
endmodule
